// File: rtl/timer_pkg.sv
// ============================================================================
// Module : timer_pkg
// Brief  : Register map, control bit indices and control struct for timer_array
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

package timer_pkg;

  localparam logic [2:0] REG_CNT0 = 3'd0;
  localparam logic [2:0] REG_CNT1 = 3'd1;
  localparam logic [2:0] REG_CNT2 = 3'd2;
  localparam logic [2:0] REG_CNT3 = 3'd3;
  localparam logic [2:0] REG_DIV  = 3'd4;
  localparam logic [2:0] REG_CTRL = 3'd5;
  localparam logic [2:0] REG_STAT = 3'd6;
  localparam logic [2:0] REG_PEND = 3'd7;

  localparam int CTRL_EN = 0;
  localparam int CTRL_IE = 1;
  localparam int CTRL_OS = 2;
  localparam int CTRL_LD = 3;

  typedef struct packed {
    logic [3:0] rsvd;
    logic       ld;
    logic       os;
    logic       ie;
    logic       en;
  } ctrl_t;

endpackage

`default_nettype wire

// File: rtl/timer_array_if.sv
// ============================================================================
// Module : timer_array_if
// Brief  : 6502-style register bus plus shared active-low interrupt line
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface timer_array_if #(
  parameter int ADDR_W = 4
);
  logic [7:0]        i_data;
  logic [7:0]        o_data;
  logic              cs;
  logic              rwb;
  logic [ADDR_W-1:0] addr;
  logic              irq;

  modport master (output i_data, cs, rwb, addr, input o_data, irq);
  modport slave  (input i_data, cs, rwb, addr, output o_data, irq);
endinterface

`default_nettype wire

// File: rtl/timer_channel.sv
// ============================================================================
// Module : timer_channel
// Brief  : One down-counting timer channel with prescaler, reload and W1C status
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module timer_channel
  import timer_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             wr_en,
  input  logic             rd_en,
  input  logic [2:0]       reg_sel,
  input  logic [7:0]       wdata,
  output logic [CNT_W-1:0] counter,
  output logic [CNT_W-1:0] snapshot,
  output logic [7:0]       divisor,
  output ctrl_t            ctrl,
  output logic             expired,
  output logic             exp_irq
);

  logic [7:0]       r_presc;
  logic [7:0]       r_div;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] r_reload;
  logic [CNT_W-1:0] r_snap;
  logic             r_en;
  logic             r_ie;
  logic             r_os;
  logic             r_exp;

  logic w_wr_ctrl;
  logic w_ld;
  logic w_tick;
  logic w_expire;

  assign w_wr_ctrl = wr_en && (reg_sel == REG_CTRL);
  assign w_ld      = w_wr_ctrl && wdata[CTRL_LD];
  assign w_tick    = r_en && (r_presc == r_div);
  // A load on a tick edge replaces the tick entirely, expiry included.
  assign w_expire  = w_tick && (r_cnt == '0) && !w_ld;

  always_ff @(negedge clk or negedge reset) begin
    if (!reset) begin
      r_presc  <= '0;
      r_div    <= '0;
      r_cnt    <= '0;
      r_reload <= '0;
      r_snap   <= '0;
      r_en     <= 1'b0;
      r_ie     <= 1'b0;
      r_os     <= 1'b0;
      r_exp    <= 1'b0;
    end else begin
      if (w_ld) begin
        r_presc <= '0;
        r_cnt   <= r_reload;
      end else begin
        if (r_en) r_presc <= w_tick ? 8'd0 : r_presc + 8'd1;
        if (w_tick) begin
          if (r_cnt != '0)  r_cnt <= r_cnt - CNT_W'(1);
          else if (!r_os)   r_cnt <= r_reload;
        end
      end

      // Control write is ordered after the one-shot EN clear so it wins.
      if (w_expire && r_os) r_en <= 1'b0;
      if (w_wr_ctrl) begin
        r_en <= wdata[CTRL_EN];
        r_ie <= wdata[CTRL_IE];
        r_os <= wdata[CTRL_OS];
      end

      if (wr_en && (reg_sel == REG_DIV)) r_div <= wdata;

      for (int b = 0; b < CNT_W / 8; b++) begin
        if (wr_en && (reg_sel == 3'(b))) r_reload[8*b +: 8] <= wdata;
      end

      if (w_expire)                                         r_exp <= 1'b1;
      else if (wr_en && (reg_sel == REG_STAT) && wdata[0])  r_exp <= 1'b0;

      if (rd_en && (reg_sel == REG_CNT0)) r_snap <= r_cnt;
    end
  end

  assign counter  = r_cnt;
  assign snapshot = r_snap;
  assign divisor  = r_div;
  assign ctrl     = '{rsvd: 4'b0, ld: 1'b0, os: r_os, ie: r_ie, en: r_en};
  assign expired  = r_exp;
  assign exp_irq  = r_exp & r_ie;

endmodule

`default_nettype wire

// File: rtl/timer_array.sv
// ============================================================================
// Module : timer_array
// Brief  : NUM_CH timer channels behind one register window and one IRQ line
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module timer_array
  import timer_pkg::*;
#(
  parameter int NUM_CH = 2,
  parameter int CNT_W  = 16,
  parameter int ADDR_W = 3 + $clog2(NUM_CH)
) (
  input  logic         clk,
  input  logic         reset,
  timer_array_if.slave bus
);

  logic [2:0]        w_reg;
  logic [ADDR_W-1:0] w_ch_idx;
  logic [CNT_W-1:0]  w_cnt  [NUM_CH];
  logic [CNT_W-1:0]  w_snap [NUM_CH];
  logic [7:0]        w_div  [NUM_CH];
  ctrl_t             w_ctrl [NUM_CH];
  logic [NUM_CH-1:0] w_exp;
  logic [NUM_CH-1:0] w_pend;
  logic [CNT_W-1:0]  w_src;
  logic [7:0]        w_rdata;

  assign w_reg    = bus.addr[2:0];
  assign w_ch_idx = bus.addr >> 3;

  generate
    for (genvar ch = 0; ch < NUM_CH; ch++) begin : g_ch
      logic w_sel;
      assign w_sel = (w_ch_idx == ADDR_W'(ch));

      timer_channel #(.CNT_W(CNT_W)) u_ch (
        .clk      (clk),
        .reset    (reset),
        .wr_en    (bus.cs & ~bus.rwb & w_sel),
        .rd_en    (bus.cs &  bus.rwb & w_sel),
        .reg_sel  (w_reg),
        .wdata    (bus.i_data),
        .counter  (w_cnt[ch]),
        .snapshot (w_snap[ch]),
        .divisor  (w_div[ch]),
        .ctrl     (w_ctrl[ch]),
        .expired  (w_exp[ch]),
        .exp_irq  (w_pend[ch])
      );
    end
  endgenerate

  // Byte 0 is live; upper bytes come from the snapshot taken on the byte-0 read.
  always_comb begin
    w_rdata = 8'h00;
    w_src   = '0;
    for (int ch = 0; ch < NUM_CH; ch++) begin
      if (w_ch_idx == ADDR_W'(ch)) begin
        w_src = (w_reg == REG_CNT0) ? w_cnt[ch] : w_snap[ch];
        case (w_reg)
          REG_CNT0, REG_CNT1, REG_CNT2, REG_CNT3:
                    w_rdata = 8'(w_src >> {w_reg[1:0], 3'b000});
          REG_DIV:  w_rdata = w_div[ch];
          REG_CTRL: w_rdata = w_ctrl[ch];
          REG_STAT: w_rdata = {7'b0, w_exp[ch]};
          default:  w_rdata = (ch == 0) ? 8'(w_pend) : 8'h00;
        endcase
      end
    end
  end

  assign bus.o_data = w_rdata;
  assign bus.irq    = ~|w_pend;

endmodule

`default_nettype wire

// File: tb/tb_timer_array.sv
// ============================================================================
// Module : tb_timer_array
// Brief  : Directed plus randomized checks of timer_array against a reference model
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_timer_array;

  localparam int NUM_CH = 3;
  localparam int CNT_W  = 16;
  localparam int ADDR_W = 5;
  localparam longint unsigned MASK = (64'd1 << CNT_W) - 1;

  logic clk   = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  timer_array_if #(.ADDR_W(ADDR_W)) bus ();

  timer_array #(.NUM_CH(NUM_CH), .CNT_W(CNT_W), .ADDR_W(ADDR_W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int total = 0;
  int bad   = 0;
  bit chk_on = 1'b0;

  // Reference model state, one entry per channel.
  longint unsigned m_cnt [NUM_CH];
  longint unsigned m_rel [NUM_CH];
  longint unsigned m_snap[NUM_CH];
  int              m_presc[NUM_CH];
  int              m_div  [NUM_CH];
  bit              m_en[NUM_CH], m_ie[NUM_CH], m_os[NUM_CH], m_exp[NUM_CH];

  task automatic check(input string name, input longint unsigned act, input longint unsigned exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int model_pend();
    int p = 0;
    for (int c = 0; c < NUM_CH; c++) if (m_exp[c] && m_ie[c]) p += (1 << c);
    return p;
  endfunction

  function automatic longint unsigned model_read(input int a);
    int ch = a >> 3;
    int r  = a & 7;
    if (ch >= NUM_CH) return 0;
    case (r)
      0:       return m_cnt[ch] & 8'hFF;
      1, 2, 3: return (r < CNT_W / 8) ? ((m_snap[ch] >> (8 * r)) & 8'hFF) : 0;
      4:       return longint'(m_div[ch]);
      5:       return longint'(m_os[ch]) * 4 + longint'(m_ie[ch]) * 2 + longint'(m_en[ch]);
      6:       return longint'(m_exp[ch]);
      default: return (ch == 0) ? longint'(model_pend()) : 0;
    endcase
  endfunction

  always @(negedge clk or negedge reset) begin
    if (!reset) begin
      for (int c = 0; c < NUM_CH; c++) begin
        m_cnt[c] = 0; m_rel[c] = 0; m_snap[c] = 0; m_presc[c] = 0; m_div[c] = 0;
        m_en[c] = 0; m_ie[c] = 0; m_os[c] = 0; m_exp[c] = 0;
      end
    end else begin
      for (int c = 0; c < NUM_CH; c++) begin
        bit sel, wr, ld, tick, expire;
        int r, d;
        sel    = bus.cs && ((int'(bus.addr) >> 3) == c);
        r      = int'(bus.addr) & 7;
        d      = int'(bus.i_data);
        wr     = sel && !bus.rwb;
        ld     = wr && (r == 5) && d[3];
        tick   = m_en[c] && (m_presc[c] == m_div[c]);
        expire = 1'b0;
        if (sel && bus.rwb && r == 0) m_snap[c] = m_cnt[c];
        if (ld) begin
          m_cnt[c]   = m_rel[c];
          m_presc[c] = 0;
        end else begin
          if (m_en[c]) m_presc[c] = tick ? 0 : (m_presc[c] + 1) % 256;
          if (tick) begin
            if (m_cnt[c] != 0) m_cnt[c] = m_cnt[c] - 1;
            else begin
              expire = 1'b1;
              if (m_os[c]) m_en[c] = 1'b0;
              else         m_cnt[c] = m_rel[c];
            end
          end
        end
        if (wr) begin
          if (r < CNT_W / 8)
            m_rel[c] = ((m_rel[c] & ~(64'hFF << (8 * r))) | (longint'(d) << (8 * r))) & MASK;
          else if (r == 4) m_div[c] = d;
          else if (r == 5) begin
            m_en[c] = d[0]; m_ie[c] = d[1]; m_os[c] = d[2];
          end else if (r == 6 && d[0]) m_exp[c] = 1'b0;
        end
        if (expire) m_exp[c] = 1'b1;
      end
    end
  end

  // Cycle-by-cycle comparison of the read port and irq against the model.
  always @(posedge clk) begin
    #3;
    if (chk_on) begin
      check($sformatf("rdata[%0d]", bus.addr), bus.o_data, model_read(int'(bus.addr)));
      check("irq", bus.irq, (model_pend() != 0) ? 0 : 1);
    end
  end

  task automatic bus_wr(input int a, input int d);
    @(posedge clk); #1;
    bus.cs = 1'b1; bus.rwb = 1'b0; bus.addr = ADDR_W'(a); bus.i_data = 8'(d);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk); #1;
      bus.cs = 1'b0; bus.rwb = 1'b1;
    end
  endtask

  task automatic rd_chk(input int a, input int e, input string name);
    @(posedge clk); #1;
    bus.cs = 1'b1; bus.rwb = 1'b1; bus.addr = ADDR_W'(a);
    #2 check(name, bus.o_data, longint'(e));
  endtask

  task automatic chk_irq(input int e, input string name);
    @(posedge clk); #1;
    bus.cs = 1'b0; bus.rwb = 1'b1;
    #2 check(name, bus.irq, longint'(e));
  endtask

  task automatic rand_cycle();
    int a, d;
    @(posedge clk); #1;
    a = $urandom_range(0, 31);
    d = $urandom_range(0, 255);
    if ((a & 7) == 4) d = d & 3;
    if ((a & 7) == 5 && $urandom_range(0, 1) == 1) d = d | 1;
    bus.cs     = ($urandom_range(0, 3) != 0);
    bus.rwb    = $urandom_range(0, 1) == 1;
    bus.addr   = ADDR_W'(a);
    bus.i_data = 8'(d);
  endtask

  initial begin
    bus.cs = 1'b0; bus.rwb = 1'b1; bus.addr = '0; bus.i_data = 8'h00;
    repeat (3) @(posedge clk);
    #1 reset = 1'b1;
    chk_on = 1'b1;
    rd_chk(0, 8'h00, "rst_cnt0");
    rd_chk(5, 8'h00, "rst_ctrl");
    chk_irq(1, "rst_irq");

    // Auto-reload: reload 3, divisor 1 -> period 8
    bus_wr(0, 3); bus_wr(1, 0); bus_wr(4, 1); bus_wr(5, 8'h0B);
    idle(7);
    chk_irq(1, "ar_before");
    chk_irq(0, "ar_first");
    rd_chk(6, 1, "ar_exp");
    bus_wr(6, 1);
    chk_irq(1, "ar_w1c");
    idle(3);
    chk_irq(1, "ar_pre2");
    chk_irq(0, "ar_second");
    bus_wr(5, 0); bus_wr(6, 1);

    // One-shot on channel 1: reload 5, divisor 0
    bus_wr(8, 5); bus_wr(9, 0); bus_wr(12, 0); bus_wr(13, 8'h0D);
    for (int k = 0; k < 6; k++) rd_chk(8, 5 - k, "os_count");
    rd_chk(14, 1, "os_exp");
    rd_chk(13, 8'h04, "os_en_clr");
    idle(20);
    rd_chk(8, 0, "os_hold");

    // Tear-free read across 0x0100 -> 0x00FF
    bus_wr(0, 8'h00); bus_wr(1, 8'h01); bus_wr(4, 0); bus_wr(5, 8'h09);
    rd_chk(0, 8'h00, "tear_lo0");
    rd_chk(1, 8'h01, "tear_hi0");
    rd_chk(0, 8'hFE, "tear_lo1");
    rd_chk(1, 8'h00, "tear_hi1");

    // Collisions on channel 2
    bus_wr(16, 2); bus_wr(17, 0); bus_wr(20, 0); bus_wr(21, 8'h09);
    idle(2);
    bus_wr(22, 1);
    bus_wr(21, 8'h09);
    rd_chk(16, 2, "ld_on_tick");
    rd_chk(22, 1, "w1c_on_exp");

    // Pending vector and IE masking
    bus_wr(13, 8'h02);
    rd_chk(7, 8'h02, "pend_vec");
    chk_irq(0, "pend_irq");
    rd_chk(15, 0, "pend_ch1");
    bus_wr(13, 0);
    chk_irq(1, "ie_mask_irq");
    rd_chk(14, 1, "ie_mask_exp");

    // Unmapped channel and unused counter byte
    bus_wr(29, 8'h0F);
    rd_chk(29, 0, "bad_ch");
    bus_wr(2, 8'hAA);
    rd_chk(2, 0, "byte2");

    // Reset mid-run
    bus_wr(21, 8'h03);
    chk_irq(0, "pre_reset");
    @(posedge clk); #1 reset = 1'b0; bus.cs = 1'b0;
    @(posedge clk); #1 reset = 1'b1;
    for (int a = 0; a < 32; a++) rd_chk(a, 0, "reset_zero");
    chk_irq(1, "reset_irq");
    idle(10);
    rd_chk(16, 0, "frozen_ch2");
    rd_chk(0, 0, "frozen_ch0");

    repeat (3000) rand_cycle();
    idle(2);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/timer_array.md
# timer_array

Parametrised multi-channel down-counting timer on the 6502 bus, successor to the single free-running counter. Each channel has a reload register, an 8-bit prescaler, one-shot or auto-reload mode, and a maskable interrupt. All channels combine into the shared active-low `irq` line that feeds the CPU IRQB input.

## Interface
- `NUM_CH`, default 2: channel count, 1–4.
- `CNT_W`, default 16: counter/reload width, one of 8/16/24/32.
- `ADDR_W`, default `3+$clog2(NUM_CH)` (minimum 3): address width.
- `clk  input  1`: system clock; all state updates on the falling edge.
- `reset  input  1`: one clock; reset is asynchronous and active-low.
- `i_data  input  8`: write data.
- `o_data  output  8`: read data, combinational from `addr`.
- `cs  input  1`: chip select.
- `rwb  input  1`: 1 = read, 0 = write.
- `addr  input  ADDR_W`: `addr[2:0]` selects the register, upper bits select the channel.
- `irq  output  1`: active-low interrupt request.

## Operation
- Per-channel map:
  - 0–3: counter bytes (read) / reload bytes (write), LSB first.
  - 4: divisor.
  - 5: control.
  - 6: status.
  - 7: on channel 0 only, read-only pending vector (bit n = channel n expired and IE set); reads 0 elsewhere.
- Bytes at or above `CNT_W/8` read 0 and ignore writes. Channel indices ≥ `NUM_CH` read 0 and ignore writes.
- Control bits:
  - 0 EN: run.
  - 1 IE: interrupt enable.
  - 2 OS: 1 = one-shot, 0 = auto-reload.
  - 3 LD: write-only strobe; reads 0.
  - Bits 7:4 read 0.
- Writing control with LD=1 copies reload into the counter and clears the prescaler in that same edge.
- Prescaler: 8-bit up-counter, runs only while EN=1. When it equals divisor it clears and emits a one-cycle tick, giving a tick every divisor+1 clocks. Divisor 0 ticks every clock.
- Tick with counter ≠ 0: counter decrements.
- Tick with counter = 0: status bit 0 (EXP) sets.
  - OS=0: counter reloads.
  - OS=1: counter holds 0 and EN clears.
- Period in auto-reload mode = (reload+1)·(divisor+1) clocks.
- Read snapshot: a read strobe (cs & rwb) on byte 0 captures the full counter into a snapshot at that edge. Byte 0 reads the live counter; bytes 1–3 read the snapshot, so multi-byte reads are tear-free when byte 0 is read first.
- Status is write-1-to-clear on bit 0; other bits read 0.
- `irq` = NOT (OR over channels of EXP & IE).
- Simultaneous events:
  - Expiry and W1C on the same edge: EXP ends set.
  - Expiry (OS clears EN) and a control write on the same edge: the written value wins.
  - LD and a tick on the same edge: LD wins; no decrement.
- Writing the reload register alone never touches the counter.

## Timing
- Reset values: all counters, reload, divisor, prescaler, control, status and snapshot = 0; `irq` = 1; `o_data` = 0 for every address.
- Write data is sampled at the falling edge while `cs & ~rwb`; the effect is visible immediately after that edge.
- Counter update occurs on the edge on which the prescaler matches (0 cycles of latency after the tick). EXP sets on that edge, and `irq` falls combinationally right after it.
- With EN written 1 and divisor 0, the first decrement happens on the next falling edge.
- Asserting reset mid-count clears everything asynchronously. Counting resumes only after software re-enables.

## Structure
- `timer_pkg`:
  - Register offset localparams (`REG_CNT0`..`REG_CNT3`, `REG_DIV`, `REG_CTRL`, `REG_STAT`, `REG_PEND`).
  - Control bit indices (`CTRL_EN`, `CTRL_IE`, `CTRL_OS`, `CTRL_LD`).
  - Packed `ctrl_t` struct.
- Sub-module `timer_channel` (parameter `CNT_W`): holds one channel's prescaler, counter, reload, snapshot, control and status. It takes decoded per-channel write/read strobes and exposes counter, snapshot, registers and `exp_irq`.
- `timer_array` instantiates `NUM_CH` copies via generate and does address decode, the read mux and the `irq` reduction.

## Test plan
- Reset: pulse reset low mid-run → all bytes read 0, `irq`=1, and the counter stays frozen after release.
- Auto-reload with reload=3, divisor=1, EN|IE → EXP every 8 clocks, `irq` low after the first expiry, and W1C status raises `irq` until the next expiry.
- One-shot with reload=5, divisor=0, EN|OS → counter reads 5..0, EXP sets once, EN reads 0, and the counter holds 0 for 20 further clocks.
- Tear-free read (`CNT_W`=16): reload=0x0100, divisor=0, run to 0x0100→0x00FF crossing; read byte 0 then byte 1 across the boundary → the pair is consistent (0x00/0x01 or 0xFF/0x00, never 0xFF/0x01).
- Collisions: a W1C on the expiry edge leaves EXP=1. LD on a tick edge loads reload exactly, with no decrement.
- `NUM_CH`=2: channel 1 alone expires with IE → pending register at channel 0 offset 7 reads 0x02, and `irq` is low. Clearing IE on channel 1 → `irq`=1 while EXP stays 1.
